// File: rtl/vscale_htif_pcr_arbiter_pkg.sv
// Shared types and widths for the two-requester HTIF PCR arbiter.
// The width defaults mirror the core's CSR address width and PCR data width.
package vscale_htif_pcr_arbiter_pkg;

    localparam int CSR_ADDR_WIDTH = 12;
    localparam int HTIF_PCR_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/vscale_rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright; when both
// requesters are asking, the one that was not granted last time wins.
module vscale_rr_arb2
    import vscale_htif_pcr_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       idx
);

    always_comb begin
        idx = 1'b0;
        case (req)
            2'b10:   idx = 1'b1;
            2'b11:   idx = ~last;
            default: idx = 1'b0;
        endcase
        gnt = (|req) ? onehot2(idx) : 2'b00;
    end

endmodule

// File: rtl/vscale_htif_pcr_arbiter.sv
// Shares the core's single HTIF PCR request/response channel between the test
// harness (port 0) and the debug/loader agent (port 1), one transaction at a time.
module vscale_htif_pcr_arbiter
    import vscale_htif_pcr_arbiter_pkg::*;
#(
    parameter int ADDR_W = CSR_ADDR_WIDTH,
    parameter int DATA_W = HTIF_PCR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            rq_valid,
    output logic [1:0]            rq_ready,
    input  logic [1:0]            rq_rw,
    input  logic [2*ADDR_W-1:0]   rq_addr,
    input  logic [2*DATA_W-1:0]   rq_data,
    output logic [1:0]            rs_valid,
    input  logic [1:0]            rs_ready,
    output logic [DATA_W-1:0]     rs_data,
    output logic                  htif_pcr_req_valid,
    input  logic                  htif_pcr_req_ready,
    output logic                  htif_pcr_req_rw,
    output logic [ADDR_W-1:0]     htif_pcr_req_addr,
    output logic [DATA_W-1:0]     htif_pcr_req_data,
    input  logic                  htif_pcr_resp_valid,
    output logic                  htif_pcr_resp_ready,
    input  logic [DATA_W-1:0]     htif_pcr_resp_data,
    output logic                  busy,
    output logic                  owner
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last;
    logic              r_owner;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        w_gnt;
    logic              w_idx;
    logic              w_accept;

    vscale_rr_arb2 u_arb (
        .req  (rq_valid),
        .last (r_last),
        .gnt  (w_gnt),
        .idx  (w_idx)
    );

    // Every handshake output is held low while reset_n is asserted, so nothing
    // is accepted or forwarded during the reset cycle itself.
    always_comb begin
        w_state_nxt         = r_state;
        w_accept            = 1'b0;
        rq_ready            = 2'b00;
        htif_pcr_req_valid  = 1'b0;
        rs_valid            = 2'b00;
        htif_pcr_resp_ready = 1'b0;
        if (reset_n) begin
            case (r_state)
                ST_IDLE: begin
                    rq_ready = w_gnt;
                    w_accept = |rq_valid;
                    if (w_accept) w_state_nxt = ST_ISSUE;
                end
                ST_ISSUE: begin
                    htif_pcr_req_valid = 1'b1;
                    if (htif_pcr_req_ready) w_state_nxt = ST_WAIT_RESP;
                end
                ST_WAIT_RESP: begin
                    rs_valid            = onehot2(r_owner) & {2{htif_pcr_resp_valid}};
                    htif_pcr_resp_ready = rs_ready[r_owner];
                    if (htif_pcr_resp_valid && rs_ready[r_owner]) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last  <= w_idx;
                r_owner <= w_idx;
                r_rw    <= rq_rw[w_idx];
                r_addr  <= w_idx ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
                r_data  <= w_idx ? rq_data[2*DATA_W-1:DATA_W] : rq_data[DATA_W-1:0];
            end
        end
    end

    assign htif_pcr_req_rw   = r_rw;
    assign htif_pcr_req_addr = r_addr;
    assign htif_pcr_req_data = r_data;
    assign rs_data           = htif_pcr_resp_data;
    assign busy              = reset_n && (r_state != ST_IDLE);
    assign owner             = r_owner;

endmodule
